nn_weight_config_tx: RTL and testbench

- Configuration-bus transmitter for the fully connected accelerator.
- Accepts a 32-bit word stream (header plus payload) from the host/DMA side with valid/ready handshake.
- Drives the broadcast weight/bias load bus that every neuron listens on: weightValid, biasValid, weightValue, biasValue, config_layer_num, config_neuron_num.
- One instance per accelerator, placed between the host interface and the layer array.

---
 rtl/nn_weight_config_tx.sv | 206 ++++++++++++++++++++
 tb/tb_nn_weight_config_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_weight_config_tx.sv
// nn_weight_config_tx: configuration-bus transmitter for the fully connected
// accelerator. Takes a header + payload word stream from the host/DMA side
// and drives the broadcast weight/bias load bus seen by every neuron.
//
// Optional feature macro: NN_WCFG_CHECKSUM_EN
//   When defined, every load is followed by one trailer word that must equal
//   the 32-bit wrap-around sum of the header and all payload words. load_done
//   then pulses one cycle after a matching trailer; a mismatch sets cfg_err.
//
// state  | meaning
// S_HDR  | waiting for a header word; bad headers set cfg_err and are dropped
// S_DATA | forwarding payload words as one-cycle strobes, cnt counts down
// S_TRL  | (checksum builds only) waiting for the trailer word
module nn_weight_config_tx #(
    parameter int NUM_LAYERS  = 4,
    parameter int MAX_NEURONS = 64,
    parameter int MAX_WEIGHTS = 1024,
    parameter int CNT_W       = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        pause,
    output logic        weightValid,
    output logic        biasValid,
    output logic [31:0] weightValue,
    output logic [31:0] biasValue,
    output logic [31:0] config_layer_num,
    output logic [31:0] config_neuron_num,
    output logic        load_done,
    output logic        cfg_err
);

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
`ifdef NN_WCFG_CHECKSUM_EN
        S_TRL  = 2'd2,
`endif
        S_DATA = 2'd1
    } state_t;

    localparam logic [8:0]       LAYER_MAX = 9'(NUM_LAYERS);
    localparam logic [8:0]       NEUR_LIM  = 9'(MAX_NEURONS);
    localparam logic [CNT_W:0]   WMAX      = (CNT_W+1)'(MAX_WEIGHTS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             type_q, type_d;
    logic             wv_q, wv_d;
    logic             bv_q, bv_d;
    logic [31:0]      wval_q, wval_d;
    logic [31:0]      bval_q, bval_d;
    logic [31:0]      layer_q, layer_d;
    logic [31:0]      neuron_q, neuron_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
`ifdef NN_WCFG_CHECKSUM_EN
    logic [31:0]      sum_q, sum_d;
`endif

    logic [7:0]       hdr_layer;
    logic [7:0]       hdr_neuron;
    logic             hdr_type;
    logic [CNT_W-1:0] hdr_cnt;
    logic             hdr_bad;
    logic             accept;

    assign hdr_layer  = s_data[31:24];
    assign hdr_neuron = s_data[23:16];
    assign hdr_type   = s_data[15];
    assign hdr_cnt    = s_data[CNT_W-1:0];

    assign hdr_bad = (hdr_layer == 8'd0)
                   | ({1'b0, hdr_layer} > LAYER_MAX)
                   | ({1'b0, hdr_neuron} >= NEUR_LIM)
                   | (hdr_cnt == '0)
                   | (!hdr_type && ({1'b0, hdr_cnt} > WMAX))
                   | (hdr_type && (hdr_cnt != CNT_ONE));

`ifdef NN_WCFG_CHECKSUM_EN
    assign s_ready = !pause & ((state_q == S_HDR) | (state_q == S_DATA) | (state_q == S_TRL));
`else
    assign s_ready = !pause & ((state_q == S_HDR) | (state_q == S_DATA));
`endif
    assign accept  = s_valid & s_ready;

    // Register state and all bus outputs; synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_HDR;
            cnt_q    <= '0;
            type_q   <= 1'b0;
            wv_q     <= 1'b0;
            bv_q     <= 1'b0;
            wval_q   <= '0;
            bval_q   <= '0;
            layer_q  <= '0;
            neuron_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef NN_WCFG_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            type_q   <= type_d;
            wv_q     <= wv_d;
            bv_q     <= bv_d;
            wval_q   <= wval_d;
            bval_q   <= bval_d;
            layer_q  <= layer_d;
            neuron_q <= neuron_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef NN_WCFG_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    // Next-state, header decode, payload strobes and error/done generation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        type_d   = type_q;
        wv_d     = 1'b0;
        bv_d     = 1'b0;
        wval_d   = wval_q;
        bval_d   = bval_q;
        layer_d  = layer_q;
        neuron_d = neuron_q;
        done_d   = 1'b0;
        err_d    = err_q;
`ifdef NN_WCFG_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        case (state_q)
            S_HDR: begin
                if (accept) begin
                    if (hdr_bad) begin
                        err_d = 1'b1;
                    end else begin
                        layer_d  = {24'd0, hdr_layer};
                        neuron_d = {24'd0, hdr_neuron};
                        cnt_d    = hdr_cnt;
                        type_d   = hdr_type;
                        state_d  = S_DATA;
`ifdef NN_WCFG_CHECKSUM_EN
                        sum_d    = s_data;
`endif
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (type_q) begin
                        bv_d   = 1'b1;
                        bval_d = s_data;
                    end else begin
                        wv_d   = 1'b1;
                        wval_d = s_data;
                    end
                    cnt_d = cnt_q - CNT_ONE;
`ifdef NN_WCFG_CHECKSUM_EN
                    sum_d = sum_q + s_data;
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_TRL;
                    end
`else
                    if (cnt_q == CNT_ONE) begin
                        done_d  = 1'b1;
                        state_d = S_HDR;
                    end
`endif
                end
            end
`ifdef NN_WCFG_CHECKSUM_EN
            S_TRL: begin
                if (accept) begin
                    if (s_data == sum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_HDR;
                end
            end
`endif
            default: state_d = S_HDR;
        endcase
    end

    assign weightValid       = wv_q;
    assign biasValid         = bv_q;
    assign weightValue       = wval_q;
    assign biasValue         = bval_q;
    assign config_layer_num  = layer_q;
    assign config_neuron_num = neuron_q;
    assign load_done         = done_q;
    assign cfg_err           = err_q;

endmodule

// File: tb/tb_nn_weight_config_tx.sv
// Directed testbench for nn_weight_config_tx (default and checksum builds).
module tb_nn_weight_config_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        pause;
    logic        weightValid;
    logic        biasValid;
    logic [31:0] weightValue;
    logic [31:0] biasValue;
    logic [31:0] config_layer_num;
    logic [31:0] config_neuron_num;
    logic        load_done;
    logic        cfg_err;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sum;

`ifdef NN_WCFG_CHECKSUM_EN
    localparam logic LD = 1'b0;
`else
    localparam logic LD = 1'b1;
`endif

    nn_weight_config_tx dut (
        .clk               (clk),
        .rst               (rst),
        .s_data            (s_data),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .pause             (pause),
        .weightValid       (weightValid),
        .biasValid         (biasValid),
        .weightValue       (weightValue),
        .biasValue         (biasValue),
        .config_layer_num  (config_layer_num),
        .config_neuron_num (config_neuron_num),
        .load_done         (load_done),
        .cfg_err           (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted; returns #1 after the accept edge.
    task automatic xfer(input logic [31:0] d);
        int n;
        n = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            cyc();
            n++;
        end
        if (n >= 50) chk("xfer_timeout", 32'(n), 32'd0);
        cyc();
        s_valid = 1'b0;
    endtask

    task automatic hdr(input logic [31:0] d);
        sum = d;
        xfer(d);
    endtask

    task automatic pay(input logic [31:0] d);
        sum = sum + d;
        xfer(d);
    endtask

`ifdef NN_WCFG_CHECKSUM_EN
    task automatic trailer(input logic [31:0] d, input logic ok);
        xfer(d);
        chk("trl_done", load_done, ok);
        chk("trl_wv", weightValid, 1'b0);
        chk("trl_bv", biasValid, 1'b0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int nstrobe;
        logic acc;
        rst = 1'b1; s_data = '0; s_valid = 1'b0; pause = 1'b0;
        repeat (3) cyc();
        chk("rst_wv", weightValid, 1'b0);
        chk("rst_bv", biasValid, 1'b0);
        chk("rst_wval", weightValue, 32'd0);
        chk("rst_layer", config_layer_num, 32'd0);
        chk("rst_done", load_done, 1'b0);
        chk("rst_err", cfg_err, 1'b0);
        chk("rst_ready", s_ready, 1'b1);
        rst = 1'b0;
        cyc();

        // Weight load: layer 2, neuron 13, 30 words
        hdr(32'h020D001E);
        chk("w_hdr_layer", config_layer_num, 32'd2);
        chk("w_hdr_neuron", config_neuron_num, 32'd13);
        chk("w_hdr_wv", weightValid, 1'b0);
        for (int i = 0; i < 30; i++) begin
            pay(32'(i));
            chk("w_wv", weightValid, 1'b1);
            chk("w_wval", weightValue, 32'(i));
            chk("w_bv", biasValid, 1'b0);
            chk("w_layer", config_layer_num, 32'd2);
            chk("w_neuron", config_neuron_num, 32'd13);
            chk("w_done", load_done, LD && (i == 29));
        end
`ifdef NN_WCFG_CHECKSUM_EN
        trailer(sum, 1'b1);
`endif
        cyc();
        chk("w_idle_wv", weightValid, 1'b0);
        chk("w_idle_done", load_done, 1'b0);
        chk("w_hold_wval", weightValue, 32'h1D);

        // Bias load
        hdr(32'h020D8001);
        pay(32'h0000FD5C);
        chk("b_bv", biasValid, 1'b1);
        chk("b_bval", biasValue, 32'h0000FD5C);
        chk("b_wv", weightValid, 1'b0);
        chk("b_done", load_done, LD);
        chk("b_hold_wval", weightValue, 32'h1D);
`ifdef NN_WCFG_CHECKSUM_EN
        trailer(sum, 1'b1);
`endif
        cyc();
        chk("b_idle_bv", biasValid, 1'b0);

        // Flow control: layer 1, neuron 5, 5 weights, valid every other cycle, pause 3 cycles
        hdr(32'h01050005);
        idx = 0;
        nstrobe = 0;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            pause   = (c >= 3 && c <= 5);
            s_valid = (c % 2 == 0);
            s_data  = 32'hA0 + 32'(idx);
            #1;
            chk("f_ready", s_ready, !pause);
            acc = s_valid && !pause;
            @(posedge clk);
            #1;
            if (weightValid) nstrobe++;
            if (acc) begin
                chk("f_wv", weightValid, 1'b1);
                chk("f_wval", weightValue, 32'hA0 + 32'(idx));
                sum = sum + 32'hA0 + 32'(idx);
                idx++;
                chk("f_done", load_done, LD && (idx == 5));
            end else begin
                chk("f_nostrobe", weightValid, 1'b0);
            end
        end
        s_valid = 1'b0;
        pause   = 1'b0;
        cyc();
        if (weightValid) nstrobe++;
        chk("f_strobes", 32'(nstrobe), 32'd5);
`ifdef NN_WCFG_CHECKSUM_EN
        trailer(sum, 1'b1);
`endif

        // Bad headers, then a good one
        chk("bad_err_before", cfg_err, 1'b0);
        xfer(32'h000D0005);
        chk("bad0_err", cfg_err, 1'b1);
        chk("bad0_wv", weightValid, 1'b0);
        chk("bad0_layer", config_layer_num, 32'd1);
        chk("bad0_neuron", config_neuron_num, 32'd5);
        xfer(32'h020D8002);
        chk("bad1_bv", biasValid, 1'b0);
        chk("bad1_wv", weightValid, 1'b0);
        chk("bad1_layer", config_layer_num, 32'd1);
        chk("bad1_ready", s_ready, 1'b1);
        hdr(32'h03070002);
        chk("g_layer", config_layer_num, 32'd3);
        chk("g_neuron", config_neuron_num, 32'd7);
        pay(32'h11);
        chk("g_wv0", weightValid, 1'b1);
        chk("g_wval0", weightValue, 32'h11);
        chk("g_done0", load_done, 1'b0);
        pay(32'h22);
        chk("g_wv1", weightValid, 1'b1);
        chk("g_wval1", weightValue, 32'h22);
        chk("g_done1", load_done, LD);
`ifdef NN_WCFG_CHECKSUM_EN
        trailer(sum, 1'b1);
`endif
        chk("g_err_sticky", cfg_err, 1'b1);

        // Reset mid-load after 10 of 30 weights
        hdr(32'h020D001E);
        for (int i = 0; i < 10; i++) pay(32'h100 + 32'(i));
        s_data  = 32'h10A;
        s_valid = 1'b1;
        rst     = 1'b1;
        cyc();
        chk("r_wv", weightValid, 1'b0);
        chk("r_bv", biasValid, 1'b0);
        chk("r_wval", weightValue, 32'd0);
        chk("r_bval", biasValue, 32'd0);
        chk("r_layer", config_layer_num, 32'd0);
        chk("r_neuron", config_neuron_num, 32'd0);
        chk("r_done", load_done, 1'b0);
        chk("r_err", cfg_err, 1'b0);
        rst     = 1'b0;
        s_valid = 1'b0;
        cyc();
        chk("r_after_wv", weightValid, 1'b0);
        hdr(32'h04030001);
        chk("r_new_layer", config_layer_num, 32'd4);
        chk("r_new_neuron", config_neuron_num, 32'd3);
        pay(32'hDEADBEEF);
        chk("r_new_wv", weightValid, 1'b1);
        chk("r_new_wval", weightValue, 32'hDEADBEEF);
        chk("r_new_done", load_done, LD);
`ifdef NN_WCFG_CHECKSUM_EN
        // Correct trailer: 0x04030001 + 0xDEADBEEF = 0xE2B0BEF0
        trailer(32'hE2B0BEF0, 1'b1);
        chk("ck_ok_err", cfg_err, 1'b0);
        // Off-by-one trailer: 0x01000001 + 5 = 0x01000006, send 0x01000007
        hdr(32'h01000001);
        pay(32'h5);
        trailer(32'h01000007, 1'b0);
        chk("ck_bad_err", cfg_err, 1'b1);
`endif
        cyc();
        chk("end_wv", weightValid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
